// File: rtl/prefetch_queue_fetcher_if.sv
// Bus bundle between the prefetch queue fetcher (master), instruction memory and decode (slave).
// Handshakes: a transfer happens on a rising clk edge where the producer's valid and the consumer's ready are both high;
// memory ready means data for the presented address is on inst_mem_out_data in that same cycle.
interface prefetch_queue_fetcher_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [ADDR_W-1:0] inst_pc;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] inst_mem_out_addr;
    logic              inst_mem_out_valid;
    logic [DATA_W-1:0] inst_mem_out_data;
    logic              inst_mem_out_ready;

    modport master (
        input  redirect_valid, redirect_pc, inst_ready, inst_mem_out_data, inst_mem_out_ready,
        output inst_valid, inst_pc, instruction, inst_mem_out_addr, inst_mem_out_valid
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_ready, inst_mem_out_data, inst_mem_out_ready,
        input  inst_valid, inst_pc, instruction, inst_mem_out_addr, inst_mem_out_valid
    );
endinterface

// File: rtl/prefetch_queue_fetcher.sv
// Sequential instruction prefetcher feeding a DEPTH-entry {pc, instruction} queue; redirect flushes and restarts.
// Optional FETCHER_STATS_EN adds push / full-cycle / flush counters.
module prefetch_queue_fetcher #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset,
    prefetch_queue_fetcher_if.master bus
`ifdef FETCHER_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_full_cycles,
    output logic [31:0] stat_flushes
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W:0]    count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic full;
    logic req;
    logic head_valid;
    logic push;
    logic pop;

    // STALLED phase is simply full; the request only reopens once the registered count has dropped.
    always_comb begin
        full       = (count == CNT_FULL);
        req        = !reset && !bus.redirect_valid && !full;
        head_valid = (count != '0) && !bus.redirect_valid && !reset;
        push       = req && bus.inst_mem_out_ready;
        pop        = head_valid && bus.inst_ready;
    end

    assign bus.inst_mem_out_valid = req;
    assign bus.inst_mem_out_addr  = fetch_pc;
    assign bus.inst_valid         = head_valid;
    assign bus.inst_pc            = pc_mem[rd_ptr];
    assign bus.instruction        = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & PC_MASK;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= bus.inst_mem_out_data;
        end
    end

`ifdef FETCHER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched     <= '0;
            stat_full_cycles <= '0;
            stat_flushes     <= '0;
        end else begin
            if (push) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (full) begin
                stat_full_cycles <= stat_full_cycles + 32'd1;
            end
            if (bus.redirect_valid && (count != '0)) begin
                stat_flushes <= stat_flushes + 32'd1;
            end
        end
    end
`endif

endmodule
